// File: rtl/output_conditioner.sv
// output_conditioner
// Drives one board-facing pin from level requests in the clk domain. Every
// level is held for at least HOLDTIME cycles, so a far-end debouncer with an
// equal or shorter wait never sees chatter. A one-entry pending buffer lets
// the producer post the next level while the current one is still held.
module output_conditioner #(
    parameter int   HOLDTIME     = 4,
    parameter int   COUNTERWIDTH = 8,
    parameter logic RESETLEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic pin,
    output logic positiveedge,
    output logic negativeedge,
    output logic busy
);

    // Counter reload after a pin change: the change cycle itself counts as the
    // first held cycle, so HOLDTIME-1 more cycles must pass before the next one.
    localparam logic [COUNTERWIDTH-1:0] LOAD = COUNTERWIDTH'(HOLDTIME - 1);

    // State is fully determined by the counter and the pending flag.
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_HOLD_PEND = 2'd2;

    logic                    pin_q,       pin_d;
    logic                    pos_q,       pos_d;
    logic                    neg_q,       neg_d;
    logic [COUNTERWIDTH-1:0] count_q,     count_d;
    logic                    pend_full_q, pend_full_d;
    logic                    pend_lvl_q,  pend_lvl_d;
    logic [1:0]              state;
    logic                    xfer;
    logic                    apply;

    assign req_ready    = !pend_full_q;
    assign busy         = (count_q != '0) || pend_full_q;
    assign xfer         = req_valid && !pend_full_q;
    assign pin          = pin_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;

    // Decode the operating state from registered counter and pending flag.
    always_comb begin
        if (pend_full_q) begin
            state = S_HOLD_PEND;
        end else if (count_q != '0) begin
            state = S_HOLD;
        end else begin
            state = S_IDLE;
        end
    end

    // Next-state logic: decide whether the pin toggles this edge, and manage
    // the hold counter and the pending buffer.
    always_comb begin
        pin_d       = pin_q;
        pos_d       = 1'b0;
        neg_d       = 1'b0;
        count_d     = count_q;
        pend_full_d = pend_full_q;
        pend_lvl_d  = pend_lvl_q;
        apply       = 1'b0;

        case (state)
            S_IDLE: begin
                // A request equal to the current level is accepted and dropped.
                if (xfer && (req_level != pin_q)) begin
                    apply = 1'b1;
                end
            end
            S_HOLD: begin
                count_d = count_q - 1'b1;
                if (xfer) begin
                    pend_full_d = 1'b1;
                    pend_lvl_d  = req_level;
                end
            end
            S_HOLD_PEND: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Hold expired: release the buffer; a pending level that
                    // matches the pin is discarded without any edge.
                    pend_full_d = 1'b0;
                    if (pend_lvl_q != pin_q) begin
                        apply = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (apply) begin
            pin_d   = ~pin_q;
            pos_d   = ~pin_q;
            neg_d   = pin_q;
            count_d = LOAD;
        end
    end

    // Control and output registers; reset returns to an idle, empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q       <= RESETLEVEL;
            pos_q       <= 1'b0;
            neg_q       <= 1'b0;
            count_q     <= '0;
            pend_full_q <= 1'b0;
        end else begin
            pin_q       <= pin_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            count_q     <= count_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Pending level is only meaningful while pend_full_q is set.
    always_ff @(posedge clk) begin
        pend_lvl_q <= pend_lvl_d;
    end

endmodule

// File: tb/tb_output_conditioner.sv
// tb_output_conditioner
// Directed stimulus for output_conditioner with a level/hold-age model and a
// per-cycle compare process.
module tb_output_conditioner;

    localparam int H = 4;

    logic clk       = 1'b1;
    logic rst_n     = 1'b1;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic req_ready;
    logic pin;
    logic positiveedge;
    logic negativeedge;
    logic busy;

    int checks = 0;
    int errors = 0;

    output_conditioner #(
        .HOLDTIME    (H),
        .COUNTERWIDTH(8),
        .RESETLEVEL  (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_level   (req_level),
        .req_ready   (req_ready),
        .pin         (pin),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: pin level, how many cycles it has been shown, and an optional
    // queued request. A change is allowed once the level has been held H cycles.
    logic m_pin     = 1'b0;
    logic m_pos     = 1'b0;
    logic m_neg     = 1'b0;
    logic m_pend_v  = 1'b0;
    logic m_pend_l  = 1'b0;
    int   m_held    = H;
    logic m_busy;
    logic m_can, m_chg, n_pv, n_pl;

    assign m_busy = (m_held < H) || m_pend_v;

    always_comb begin
        m_can = (m_held >= H);
        m_chg = 1'b0;
        n_pv  = m_pend_v;
        n_pl  = m_pend_l;
        if (m_pend_v) begin
            if (m_can) begin
                n_pv  = 1'b0;
                m_chg = (m_pend_l != m_pin);
            end
        end else if (req_valid) begin
            if (m_can) begin
                m_chg = (req_level != m_pin);
            end else begin
                n_pv = 1'b1;
                n_pl = req_level;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pin    <= 1'b0;
            m_pos    <= 1'b0;
            m_neg    <= 1'b0;
            m_pend_v <= 1'b0;
            m_pend_l <= 1'b0;
            m_held   <= H;
        end else begin
            m_pin    <= m_chg ? ~m_pin : m_pin;
            m_pos    <= m_chg & ~m_pin;
            m_neg    <= m_chg & m_pin;
            m_pend_v <= n_pv;
            m_pend_l <= n_pl;
            m_held   <= m_chg ? 1 : ((m_held < 1000) ? m_held + 1 : m_held);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic lvl);
        req_valid = 1'b1;
        req_level = lvl;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("idle_timeout_busy", int'(busy), 0);
    endtask

    // Per-cycle comparison against the model, plus run-length and pulse
    // consistency of the observed pin.
    task automatic compare_loop;
        logic prev_pin = 1'b0;
        int   run      = H;
        forever begin
            @(negedge clk);
            chk("cmp_pin",   int'(pin),          int'(m_pin));
            chk("cmp_pos",   int'(positiveedge), int'(m_pos));
            chk("cmp_neg",   int'(negativeedge), int'(m_neg));
            chk("cmp_ready", int'(req_ready),    int'(!m_pend_v));
            chk("cmp_busy",  int'(busy),         int'(m_busy));
            if (rst_n) begin
                if (pin !== prev_pin) begin
                    chk("min_hold_ok", int'(run >= H), 1);
                    chk("pulse_dir", int'({positiveedge, negativeedge}), int'({pin, ~pin}));
                    run = 1;
                end else begin
                    chk("no_pulse", int'({positiveedge, negativeedge}), 0);
                    if (run < 1000) run++;
                end
            end else begin
                run = H;
            end
            prev_pin = pin;
        end
    endtask

    task automatic stimulus;
        // Reset
        #1 rst_n = 1'b0;
        #11;
        chk("rst_pin",   int'(pin), 0);
        chk("rst_pos",   int'(positiveedge), 0);
        chk("rst_neg",   int'(negativeedge), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy",  int'(busy), 0);
        #23 rst_n = 1'b1;
        step();
        chk("rel_pin", int'(pin), 0);
        chk("rel_pos", int'(positiveedge), 0);
        chk("rel_neg", int'(negativeedge), 0);

        // Single change
        send(1'b1);
        chk("single_pin",   int'(pin), 1);
        chk("single_pos",   int'(positiveedge), 1);
        chk("single_busy1", int'(busy), 1);
        chk("single_ready", int'(req_ready), 1);
        step();
        chk("single_pos_off", int'(positiveedge), 0);
        chk("single_busy2",   int'(busy), 1);
        step();
        chk("single_busy3", int'(busy), 1);
        step();
        chk("single_busy_end", int'(busy), 0);
        send(1'b0);
        chk("fall_pin", int'(pin), 0);
        chk("fall_neg", int'(negativeedge), 1);
        wait_idle();

        // Back-to-back posting with a third request held off by ready
        req_valid = 1'b1;
        req_level = 1'b1;
        step();
        chk("b2b_rise", int'(pin), 1);
        req_level = 1'b0;
        step();
        chk("b2b_ready_lo", int'(req_ready), 0);
        chk("b2b_pin_a1",   int'(pin), 1);
        req_level = 1'b1;
        step();
        chk("b2b_ready_a2", int'(req_ready), 0);
        step();
        chk("b2b_pin_a3", int'(pin), 1);
        step();
        chk("b2b_fall_pin",  int'(pin), 0);
        chk("b2b_fall_neg",  int'(negativeedge), 1);
        chk("b2b_ready_ret", int'(req_ready), 1);
        step();
        req_valid = 1'b0;
        chk("b2b_third_acc", int'(req_ready), 0);
        step();
        step();
        chk("b2b_pin_a7", int'(pin), 0);
        step();
        chk("b2b_third_pin", int'(pin), 1);
        chk("b2b_third_pos", int'(positiveedge), 1);
        wait_idle();

        // Redundant request
        send(1'b0);
        wait_idle();
        send(1'b0);
        chk("redund_pin",  int'(pin), 0);
        chk("redund_neg",  int'(negativeedge), 0);
        chk("redund_busy", int'(busy), 0);

        // Cancelling request: pending equals held level
        send(1'b1);
        send(1'b1);
        chk("cancel_ready_lo", int'(req_ready), 0);
        step();
        step();
        chk("cancel_busy_b3", int'(busy), 1);
        step();
        chk("cancel_ready", int'(req_ready), 1);
        chk("cancel_busy",  int'(busy), 0);
        chk("cancel_pos",   int'(positiveedge), 0);
        chk("cancel_pin",   int'(pin), 1);

        // Chatter suppression
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            req_level = i[0];
            step();
        end
        req_valid = 1'b0;
        wait_idle();

        // Async reset mid-hold with pending full
        if (m_pin) begin
            send(1'b0);
            wait_idle();
        end
        send(1'b1);
        chk("ar_rise", int'(pin), 1);
        send(1'b0);
        chk("ar_pend", int'(req_ready), 0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pin",   int'(pin), 0);
        chk("ar_ready", int'(req_ready), 1);
        chk("ar_busy",  int'(busy), 0);
        chk("ar_pulse", int'({positiveedge, negativeedge}), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ar_post_pin", int'(pin), 0);
        send(1'b1);
        chk("ar_first_pin",  int'(pin), 1);
        chk("ar_first_pos",  int'(positiveedge), 1);
        chk("ar_first_busy", int'(busy), 1);
        wait_idle();
        step();
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
